lc3_fetch_unit: RTL and testbench
=================================

Name: lc3_fetch_unit

Overview:
- Instruction fetch stage of the LC-3 core; sits directly upstream of the IF/ID pipeline register.
- Maintains the fetch PC and issues single-outstanding requests to instruction memory.
- Presents {pc, npc, ir, valid} to the IF/ID register. Honours the downstream stall and branch/trap redirects.
- Has a one-entry skid buffer so no returned instruction is lost while stalled.

Parameters:
- AW, 16, address/PC width.
- DW, 16, instruction width.
- RESET_PC, 16'h3000, first fetch address after reset.

Ports:
- clk_i_w  in  1  clock.
- rst_i_w  in  1  reset; asynchronous, active-low.
- en_i_w  in  1  fetch enable; low = issue no new requests.
- stall_i_w  in  1  downstream hold; output slot is not consumed this cycle.
- redirect_i_w  in  1  PC redirect (branch/JMP/TRAP/RTI) from later stage.
- redirect_pc_i_w  in  AW  redirect target.
- imem_req_o_r  out  1  memory request.
- imem_addr_o_r  out  AW  request address.
- imem_gnt_i_w  in  1  request accepted this cycle.
- imem_rvalid_i_w  in  1  read data valid; arrives ≥1 cycle after gnt.
- imem_rdata_i_w  in  DW  read data.
- if_valid_o_r  out  1  output slot holds a valid instruction.
- if_ir_o_r  out  DW  instruction.
- if_pc_o_r  out  AW  address of the instruction.
- if_npc_o_r  out  AW  if_pc_o_r+1, mod 2^AW.

Behaviour:
- Reset (async, rst_i_w=0):
  - state=IDLE; fetch_pc=RESET_PC; skid empty; drop=0.
  - All outputs 0: req, addr, valid, ir, pc, npc.
  - Reset mid-transaction abandons it; any later rvalid is ignored while in IDLE.
- Consume: the slot is consumed when if_valid_o_r=1 and stall_i_w=0. valid clears on consume unless it is refilled in the same cycle.
- At most one request is outstanding. States:
  - IDLE: req=0. If en_i_w=1, go to REQ next cycle.
  - REQ: req=1, addr=fetch_pc.
    - req and addr hold until gnt. Only a redirect may change addr while ungranted.
    - On gnt: latch issued_pc=fetch_pc, set fetch_pc=fetch_pc+1 (wraps FFFF->0000), go to WAIT. req drops the next cycle.
  - WAIT: req=0. On rvalid:
    - If drop=1: discard the data, clear drop, go to REQ.
    - Else if the slot is free (valid=0 or consumed this cycle): load ir=rdata, pc=issued_pc, npc=issued_pc+1, valid=1 next cycle.
    - Else: write the skid buffer and go to FULL.
    - Next state, when not FULL: REQ if en_i_w=1, otherwise IDLE.
  - FULL: req=0. When the slot is consumed, move skid to the slot the same edge (valid stays 1). Then go to REQ if en, else IDLE.
- Throughput: with gnt the same cycle and rvalid the next cycle, one instruction every 2 cycles.
- Redirect (highest priority; overrides stall and en):
  - Next cycle: valid=0, skid empty, fetch_pc=redirect_pc_i_w.
  - From REQ without gnt: stay in REQ with the new addr next cycle.
  - From REQ with gnt in the same cycle: go to WAIT with drop=1; the granted old-path response is discarded.
  - From WAIT without rvalid: stay in WAIT, drop=1.
  - From WAIT with rvalid in the same cycle: discard the data, go to REQ.
  - From FULL or IDLE: go to REQ if en, else IDLE.
- en_i_w low does not cancel an ungranted REQ or an outstanding WAIT; it only blocks the next issue.
- Stall never blocks memory acceptance. The skid buffer guarantees rvalid is always absorbed.
- The output slot is held stable while valid=1 and stall=1.

Test Plan:
- Reset release, en=1, gnt=1 every cycle, rvalid 1 cycle after gnt with rdata=addr^16'hA5A5 -> req at 3000, 3001, 3002 every 2 cycles. Slot shows pc=3000/npc=3001/ir=95A5, then 3001/3002/95A4.
- stall=1 for 6 cycles while valid=1 and a response returns -> slot holds pc=3000, FULL entered, no new req. On stall drop, pc=3001 appears next cycle with no gap; then req 3002.
- Redirect to 0x4000 in WAIT, rvalid 2 cycles later -> valid=0, old rdata never appears, next req addr=4000, slot pc=4000/npc=4001.
- Redirect to 0x5000 in the same cycle as gnt of 3001 -> 3001 data dropped; next req=5000.
- Redirect in the same cycle as rvalid -> data discarded; next req=redirect target.
- PC wrap: RESET_PC=FFFF -> slot pc=FFFF/npc=0000; next req addr=0000.
- gnt held low 5 cycles -> req/addr stable throughout.
- Assert rst_i_w low mid-WAIT -> outputs 0 immediately; after release, fetch restarts at RESET_PC; stale rvalid in IDLE ignored.

Source files
------------

// File: rtl/lc3_fetch_unit.sv
// LC-3 instruction fetch stage: single-outstanding imem requests, redirect handling,
// and a one-entry skid buffer feeding the IF/ID register.
module lc3_fetch_unit #(
    parameter int unsigned   AW       = 16,
    parameter int unsigned   DW       = 16,
    parameter logic [AW-1:0] RESET_PC = 16'h3000
) (
    input  logic          clk_i_w,
    input  logic          rst_i_w,
    input  logic          en_i_w,
    input  logic          stall_i_w,
    input  logic          redirect_i_w,
    input  logic [AW-1:0] redirect_pc_i_w,
    output logic          imem_req_o_r,
    output logic [AW-1:0] imem_addr_o_r,
    input  logic          imem_gnt_i_w,
    input  logic          imem_rvalid_i_w,
    input  logic [DW-1:0] imem_rdata_i_w,
    output logic          if_valid_o_r,
    output logic [DW-1:0] if_ir_o_r,
    output logic [AW-1:0] if_pc_o_r,
    output logic [AW-1:0] if_npc_o_r
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_FULL = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] fetch_pc_q, fetch_pc_d;
    logic [AW-1:0] issued_pc_q, issued_pc_d;
    logic          drop_q, drop_d;
    logic [DW-1:0] skid_ir_q;
    logic [AW-1:0] skid_pc_q;

    logic          skid_we;
    logic          rsp_load;
    logic          skid_load;
    logic          consume;
    logic          slot_free;

    logic          req_d;
    logic [AW-1:0] addr_d;
    logic          valid_d;
    logic [DW-1:0] ir_d;
    logic [AW-1:0] pc_d;
    logic [AW-1:0] npc_d;

    assign consume   = if_valid_o_r & ~stall_i_w;
    assign slot_free = ~if_valid_o_r | consume;

    // State, datapath and registered outputs; skid is occupied exactly while in FULL.
    always_ff @(posedge clk_i_w or negedge rst_i_w) begin
        if (!rst_i_w) begin
            state_q       <= ST_IDLE;
            fetch_pc_q    <= RESET_PC;
            issued_pc_q   <= '0;
            drop_q        <= 1'b0;
            skid_ir_q     <= '0;
            skid_pc_q     <= '0;
            imem_req_o_r  <= 1'b0;
            imem_addr_o_r <= '0;
            if_valid_o_r  <= 1'b0;
            if_ir_o_r     <= '0;
            if_pc_o_r     <= '0;
            if_npc_o_r    <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            issued_pc_q   <= issued_pc_d;
            drop_q        <= drop_d;
            if (skid_we) begin
                skid_ir_q <= imem_rdata_i_w;
                skid_pc_q <= issued_pc_q;
            end
            imem_req_o_r  <= req_d;
            imem_addr_o_r <= addr_d;
            if_valid_o_r  <= valid_d;
            if_ir_o_r     <= ir_d;
            if_pc_o_r     <= pc_d;
            if_npc_o_r    <= npc_d;
        end
    end

    // Next-state and fetch bookkeeping; redirect wins over stall and enable.
    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        issued_pc_d = issued_pc_q;
        drop_d      = drop_q;
        skid_we     = 1'b0;
        rsp_load    = 1'b0;
        skid_load   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (redirect_i_w) fetch_pc_d = redirect_pc_i_w;
                if (en_i_w)       state_d    = ST_REQ;
            end
            ST_REQ: begin
                if (imem_gnt_i_w) begin
                    issued_pc_d = fetch_pc_q;
                    fetch_pc_d  = fetch_pc_q + AW'(1);
                    state_d     = ST_WAIT;
                end
                // A grant coinciding with a redirect is old-path: fetch it, then drop it.
                if (redirect_i_w) begin
                    fetch_pc_d = redirect_pc_i_w;
                    if (imem_gnt_i_w) drop_d = 1'b1;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid_i_w) begin
                    drop_d = 1'b0;
                    if (redirect_i_w || drop_q) begin
                        state_d = ST_REQ;
                    end else if (slot_free) begin
                        rsp_load = 1'b1;
                        state_d  = en_i_w ? ST_REQ : ST_IDLE;
                    end else begin
                        skid_we = 1'b1;
                        state_d = ST_FULL;
                    end
                end else if (redirect_i_w) begin
                    drop_d = 1'b1;
                end
                if (redirect_i_w) fetch_pc_d = redirect_pc_i_w;
            end
            ST_FULL: begin
                if (redirect_i_w) begin
                    fetch_pc_d = redirect_pc_i_w;
                    state_d    = en_i_w ? ST_REQ : ST_IDLE;
                end else if (consume) begin
                    skid_load = 1'b1;
                    state_d   = en_i_w ? ST_REQ : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output slot and request port values for the next cycle.
    always_comb begin
        req_d   = (state_d == ST_REQ);
        addr_d  = (state_d == ST_REQ) ? fetch_pc_d : imem_addr_o_r;
        valid_d = if_valid_o_r;
        ir_d    = if_ir_o_r;
        pc_d    = if_pc_o_r;
        npc_d   = if_npc_o_r;

        if (redirect_i_w) begin
            valid_d = 1'b0;
        end else if (rsp_load) begin
            valid_d = 1'b1;
            ir_d    = imem_rdata_i_w;
            pc_d    = issued_pc_q;
            npc_d   = issued_pc_q + AW'(1);
        end else if (skid_load) begin
            valid_d = 1'b1;
            ir_d    = skid_ir_q;
            pc_d    = skid_pc_q;
            npc_d   = skid_pc_q + AW'(1);
        end else if (consume) begin
            valid_d = 1'b0;
        end
    end

endmodule

// File: tb/tb_lc3_fetch_unit.sv
// Scoreboard bench for lc3_fetch_unit: expected request addresses and slot contents are
// queued by each scenario and popped when the DUT grants a request or hands off a slot.
module tb_lc3_fetch_unit;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] npc;
        logic [15:0] ir;
    } slot_t;

    logic        clk_i_w = 1'b0;
    logic        rst_i_w = 1'b0;
    logic        en_i_w = 1'b0;
    logic        stall_i_w = 1'b0;
    logic        redirect_i_w = 1'b0;
    logic [15:0] redirect_pc_i_w = '0;
    logic        imem_req_o_r;
    logic [15:0] imem_addr_o_r;
    logic        imem_gnt_i_w = 1'b0;
    logic        imem_rvalid_i_w = 1'b0;
    logic [15:0] imem_rdata_i_w = '0;
    logic        if_valid_o_r;
    logic [15:0] if_ir_o_r, if_pc_o_r, if_npc_o_r;

    // Second instance for the PC wrap case
    logic        en_w = 1'b0;
    logic        zero_w = 1'b0;
    logic [15:0] zero16_w = '0;
    logic        req_w, gnt_w = 1'b0, rvalid_w = 1'b0, valid_w;
    logic [15:0] addr_w, rdata_w = '0, gaddr_w = '0, ir_w, pc_w, npc_w;

    slot_t       exp_slot_q[$];
    logic [15:0] exp_req_q[$];
    slot_t       exp_s;
    logic [15:0] exp_a;
    int          checks = 0;
    int          errors = 0;
    bit          mon_on = 1'b0;

    // Memory model control
    bit          gnt_allow = 1'b1;
    int          lat = 1;
    bit          keep_pend = 1'b0;
    bit          pend = 1'b0;
    int          cnt = 0;
    logic [15:0] paddr = '0;
    logic [15:0] gaddr = '0;

    always #5 clk_i_w = ~clk_i_w;

    lc3_fetch_unit dut (
        .clk_i_w(clk_i_w), .rst_i_w(rst_i_w), .en_i_w(en_i_w), .stall_i_w(stall_i_w),
        .redirect_i_w(redirect_i_w), .redirect_pc_i_w(redirect_pc_i_w),
        .imem_req_o_r(imem_req_o_r), .imem_addr_o_r(imem_addr_o_r),
        .imem_gnt_i_w(imem_gnt_i_w), .imem_rvalid_i_w(imem_rvalid_i_w),
        .imem_rdata_i_w(imem_rdata_i_w), .if_valid_o_r(if_valid_o_r),
        .if_ir_o_r(if_ir_o_r), .if_pc_o_r(if_pc_o_r), .if_npc_o_r(if_npc_o_r)
    );

    lc3_fetch_unit #(.AW(16), .DW(16), .RESET_PC(16'hFFFF)) dut_wrap (
        .clk_i_w(clk_i_w), .rst_i_w(rst_i_w), .en_i_w(en_w), .stall_i_w(zero_w),
        .redirect_i_w(zero_w), .redirect_pc_i_w(zero16_w),
        .imem_req_o_r(req_w), .imem_addr_o_r(addr_w),
        .imem_gnt_i_w(gnt_w), .imem_rvalid_i_w(rvalid_w),
        .imem_rdata_i_w(rdata_w), .if_valid_o_r(valid_w),
        .if_ir_o_r(ir_w), .if_pc_o_r(pc_w), .if_npc_o_r(npc_w)
    );

    // Instruction memory: grant when allowed, respond lat cycles after the grant edge.
    always @(negedge clk_i_w) begin
        if (!rst_i_w && !keep_pend) begin
            pend         = 1'b0;
            imem_gnt_i_w = 1'b0;
        end
        if (imem_gnt_i_w) begin
            pend  = 1'b1;
            paddr = gaddr;
            cnt   = lat;
        end
        imem_rvalid_i_w = 1'b0;
        if (pend) begin
            cnt = cnt - 1;
            if (cnt <= 0) begin
                imem_rvalid_i_w = 1'b1;
                imem_rdata_i_w  = paddr ^ 16'hA5A5;
                pend            = 1'b0;
            end
        end
        imem_gnt_i_w = imem_req_o_r && gnt_allow;
        gaddr        = imem_addr_o_r;
    end

    // Always-ready memory for the wrap instance
    always @(negedge clk_i_w) begin
        rvalid_w = gnt_w && rst_i_w;
        rdata_w  = gaddr_w ^ 16'hA5A5;
        gnt_w    = req_w;
        gaddr_w  = addr_w;
    end

    // Scoreboard: pop on each accepted request and each slot handed downstream.
    always @(negedge clk_i_w) begin
        #2;
        if (mon_on && rst_i_w === 1'b1) begin
            if (imem_req_o_r && imem_gnt_i_w) begin
                checks++;
                if (exp_req_q.size() == 0) begin
                    errors++;
                    $display("FAIL req_sb: unexpected request addr %h", imem_addr_o_r);
                end else begin
                    exp_a = exp_req_q.pop_front();
                    if (imem_addr_o_r !== exp_a) begin
                        errors++;
                        $display("FAIL req_sb: addr %h want %h", imem_addr_o_r, exp_a);
                    end
                end
            end
            if (if_valid_o_r && !stall_i_w && !redirect_i_w) begin
                checks++;
                if (exp_slot_q.size() == 0) begin
                    errors++;
                    $display("FAIL slot_sb: unexpected slot pc %h ir %h", if_pc_o_r, if_ir_o_r);
                end else begin
                    exp_s = exp_slot_q.pop_front();
                    if ({if_pc_o_r, if_npc_o_r, if_ir_o_r} !== exp_s) begin
                        errors++;
                        $display("FAIL slot_sb: pc/npc/ir %h/%h/%h want %h/%h/%h",
                                 if_pc_o_r, if_npc_o_r, if_ir_o_r, exp_s.pc, exp_s.npc, exp_s.ir);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(negedge clk_i_w);
        #1;
    endtask

    task automatic push(input logic [15:0] a, input bit slot);
        exp_req_q.push_back(a);
        if (slot) exp_slot_q.push_back({a, a + 16'd1, a ^ 16'hA5A5});
    endtask

    task automatic do_reset();
        mon_on = 1'b0;
        rst_i_w = 1'b0;
        en_i_w = 1'b0; en_w = 1'b0; stall_i_w = 1'b0;
        redirect_i_w = 1'b0; redirect_pc_i_w = '0;
        gnt_allow = 1'b1; lat = 1; keep_pend = 1'b0;
        exp_req_q.delete();
        exp_slot_q.delete();
        tick(); tick();
        rst_i_w = 1'b1;
        mon_on = 1'b1;
    endtask

    task automatic test_reset();
        rst_i_w = 1'b0;
        tick();
        checks++;
        if ({imem_req_o_r, imem_addr_o_r, if_valid_o_r, if_ir_o_r, if_pc_o_r, if_npc_o_r} !== 66'd0) begin
            errors++;
            $display("FAIL reset_outputs: req %b addr %h valid %b ir %h pc %h npc %h want all 0",
                     imem_req_o_r, imem_addr_o_r, if_valid_o_r, if_ir_o_r, if_pc_o_r, if_npc_o_r);
        end
        rst_i_w = 1'b1;
        tick(); tick();
        checks++;
        if ({imem_req_o_r, if_valid_o_r} !== 2'b00) begin
            errors++;
            $display("FAIL reset_idle_en0: req %b valid %b want 0 0", imem_req_o_r, if_valid_o_r);
        end
    endtask

    task automatic test_throughput();
        do_reset();
        push(16'h3000, 1); push(16'h3001, 1); push(16'h3002, 1);
        en_i_w = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (i < 6) begin
                checks++;
                if ((imem_req_o_r && imem_gnt_i_w) !== (i % 2 == 0)) begin
                    errors++;
                    $display("FAIL thr_grant_cycle%0d: grant %b want %b", i,
                             imem_req_o_r && imem_gnt_i_w, i % 2 == 0);
                end
            end
            if (i == 2 || i == 4) begin
                checks++;
                exp_a = (i == 2) ? 16'h3000 : 16'h3001;
                if ({if_valid_o_r, if_pc_o_r, if_npc_o_r, if_ir_o_r} !==
                    {1'b1, exp_a, exp_a + 16'd1, exp_a ^ 16'hA5A5}) begin
                    errors++;
                    $display("FAIL thr_slot%0d: valid %b pc %h npc %h ir %h want pc %h", i,
                             if_valid_o_r, if_pc_o_r, if_npc_o_r, if_ir_o_r, exp_a);
                end
            end
            if (i == 4) en_i_w = 1'b0;
        end
        checks++;
        if (exp_req_q.size() + exp_slot_q.size() != 0) begin
            errors++;
            $display("FAIL thr_drain: %0d req %0d slot left want 0", exp_req_q.size(), exp_slot_q.size());
        end
    endtask

    task automatic test_stall();
        do_reset();
        push(16'h3000, 1); push(16'h3001, 1); push(16'h3002, 1);
        en_i_w = 1'b1;
        for (int i = 0; i < 13; i++) begin
            tick();
            if (i >= 2 && i <= 7) begin
                checks++;
                if ({if_valid_o_r, if_pc_o_r} !== {1'b1, 16'h3000}) begin
                    errors++;
                    $display("FAIL stall_hold%0d: valid %b pc %h want 1 3000", i, if_valid_o_r, if_pc_o_r);
                end
            end
            if (i >= 4 && i <= 7) begin
                checks++;
                if (imem_req_o_r !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_noreq%0d: req %b want 0", i, imem_req_o_r);
                end
            end
            if (i == 8) begin
                checks++;
                if ({if_valid_o_r, if_pc_o_r, if_npc_o_r, imem_req_o_r, imem_addr_o_r} !==
                    {1'b1, 16'h3001, 16'h3002, 1'b1, 16'h3002}) begin
                    errors++;
                    $display("FAIL stall_release: valid %b pc %h npc %h req %b addr %h want 1 3001 3002 1 3002",
                             if_valid_o_r, if_pc_o_r, if_npc_o_r, imem_req_o_r, imem_addr_o_r);
                end
                en_i_w = 1'b0;
            end
            if (i == 1) stall_i_w = 1'b1;
            if (i == 7) stall_i_w = 1'b0;
        end
        checks++;
        if (exp_req_q.size() + exp_slot_q.size() != 0) begin
            errors++;
            $display("FAIL stall_drain: %0d req %0d slot left want 0", exp_req_q.size(), exp_slot_q.size());
        end
    endtask

    task automatic test_redirect_wait();
        do_reset();
        push(16'h3000, 0); push(16'h4000, 1);
        en_i_w = 1'b1;
        lat = 3;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 1) begin
                redirect_i_w = 1'b1; redirect_pc_i_w = 16'h4000; lat = 1;
            end
            if (i == 2) redirect_i_w = 1'b0;
            if (i == 2 || i == 3) begin
                checks++;
                if ({if_valid_o_r, imem_req_o_r} !== 2'b00) begin
                    errors++;
                    $display("FAIL rdw_quiet%0d: valid %b req %b want 0 0", i, if_valid_o_r, imem_req_o_r);
                end
            end
            if (i == 4) begin
                checks++;
                if ({if_valid_o_r, imem_req_o_r, imem_addr_o_r} !== {1'b0, 1'b1, 16'h4000}) begin
                    errors++;
                    $display("FAIL rdw_newreq: valid %b req %b addr %h want 0 1 4000",
                             if_valid_o_r, imem_req_o_r, imem_addr_o_r);
                end
                en_i_w = 1'b0;
            end
            if (i == 6) begin
                checks++;
                if ({if_valid_o_r, if_pc_o_r, if_npc_o_r, if_ir_o_r} !== {1'b1, 16'h4000, 16'h4001, 16'hE5A5}) begin
                    errors++;
                    $display("FAIL rdw_slot: valid %b pc %h npc %h ir %h want 1 4000 4001 e5a5",
                             if_valid_o_r, if_pc_o_r, if_npc_o_r, if_ir_o_r);
                end
            end
        end
        checks++;
        if (exp_req_q.size() + exp_slot_q.size() != 0) begin
            errors++;
            $display("FAIL rdw_drain: %0d req %0d slot left want 0", exp_req_q.size(), exp_slot_q.size());
        end
    endtask

    task automatic test_redirect_gnt();
        do_reset();
        push(16'h3000, 0); push(16'h3001, 0); push(16'h5000, 1);
        en_i_w = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 2) begin
                checks++;
                if ({imem_req_o_r, imem_gnt_i_w, imem_addr_o_r} !== {2'b11, 16'h3001}) begin
                    errors++;
                    $display("FAIL rdg_setup: req %b gnt %b addr %h want 1 1 3001",
                             imem_req_o_r, imem_gnt_i_w, imem_addr_o_r);
                end
                redirect_i_w = 1'b1; redirect_pc_i_w = 16'h5000;
            end
            if (i == 3) begin
                redirect_i_w = 1'b0;
                checks++;
                if ({if_valid_o_r, imem_req_o_r} !== 2'b00) begin
                    errors++;
                    $display("FAIL rdg_quiet: valid %b req %b want 0 0", if_valid_o_r, imem_req_o_r);
                end
            end
            if (i == 4) begin
                checks++;
                if ({if_valid_o_r, imem_req_o_r, imem_addr_o_r} !== {1'b0, 1'b1, 16'h5000}) begin
                    errors++;
                    $display("FAIL rdg_newreq: valid %b req %b addr %h want 0 1 5000",
                             if_valid_o_r, imem_req_o_r, imem_addr_o_r);
                end
                en_i_w = 1'b0;
            end
        end
        checks++;
        if (exp_req_q.size() + exp_slot_q.size() != 0) begin
            errors++;
            $display("FAIL rdg_drain: %0d req %0d slot left want 0", exp_req_q.size(), exp_slot_q.size());
        end
    endtask

    task automatic test_redirect_rvalid();
        do_reset();
        push(16'h3000, 0); push(16'h6000, 1);
        en_i_w = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 1) begin
                redirect_i_w = 1'b1; redirect_pc_i_w = 16'h6000;
            end
            if (i == 2) begin
                redirect_i_w = 1'b0;
                checks++;
                if ({if_valid_o_r, imem_req_o_r, imem_addr_o_r} !== {1'b0, 1'b1, 16'h6000}) begin
                    errors++;
                    $display("FAIL rdr_newreq: valid %b req %b addr %h want 0 1 6000",
                             if_valid_o_r, imem_req_o_r, imem_addr_o_r);
                end
                en_i_w = 1'b0;
            end
            if (i == 4) begin
                checks++;
                if ({if_valid_o_r, if_pc_o_r, if_ir_o_r} !== {1'b1, 16'h6000, 16'hC5A5}) begin
                    errors++;
                    $display("FAIL rdr_slot: valid %b pc %h ir %h want 1 6000 c5a5",
                             if_valid_o_r, if_pc_o_r, if_ir_o_r);
                end
            end
        end
        checks++;
        if (exp_req_q.size() + exp_slot_q.size() != 0) begin
            errors++;
            $display("FAIL rdr_drain: %0d req %0d slot left want 0", exp_req_q.size(), exp_slot_q.size());
        end
    endtask

    task automatic test_gnt_low();
        do_reset();
        push(16'h3000, 1);
        gnt_allow = 1'b0;
        en_i_w = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (i <= 5) begin
                checks++;
                if ({imem_req_o_r, imem_addr_o_r} !== {1'b1, 16'h3000}) begin
                    errors++;
                    $display("FAIL gnt_low_hold%0d: req %b addr %h want 1 3000", i, imem_req_o_r, imem_addr_o_r);
                end
            end
            if (i == 2) en_i_w = 1'b0;
            if (i == 5) gnt_allow = 1'b1;
            if (i == 8) begin
                checks++;
                if ({if_valid_o_r, if_pc_o_r} !== {1'b1, 16'h3000}) begin
                    errors++;
                    $display("FAIL gnt_low_slot: valid %b pc %h want 1 3000", if_valid_o_r, if_pc_o_r);
                end
            end
            if (i == 10) begin
                checks++;
                if (imem_req_o_r !== 1'b0) begin
                    errors++;
                    $display("FAIL gnt_low_noissue: req %b want 0", imem_req_o_r);
                end
            end
        end
        checks++;
        if (exp_req_q.size() + exp_slot_q.size() != 0) begin
            errors++;
            $display("FAIL gnt_low_drain: %0d req %0d slot left want 0", exp_req_q.size(), exp_slot_q.size());
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        push(16'h3000, 0); push(16'h3000, 1);
        en_i_w = 1'b1;
        lat = 4;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (i == 1) begin
                keep_pend = 1'b1;
                en_i_w = 1'b0;
                rst_i_w = 1'b0;
                #1;
                checks++;
                if ({imem_req_o_r, imem_addr_o_r, if_valid_o_r, if_ir_o_r, if_pc_o_r, if_npc_o_r} !== 66'd0) begin
                    errors++;
                    $display("FAIL rst_mid_outputs: req %b addr %h valid %b pc %h want all 0",
                             imem_req_o_r, imem_addr_o_r, if_valid_o_r, if_pc_o_r);
                end
            end
            if (i == 3) rst_i_w = 1'b1;
            if (i == 6 || i == 7) begin
                checks++;
                if ({if_valid_o_r, imem_req_o_r} !== 2'b00) begin
                    errors++;
                    $display("FAIL rst_mid_stale%0d: valid %b req %b want 0 0", i, if_valid_o_r, imem_req_o_r);
                end
            end
            if (i == 7) begin
                keep_pend = 1'b0; lat = 1; en_i_w = 1'b1;
            end
            if (i == 8) begin
                checks++;
                if ({imem_req_o_r, imem_addr_o_r} !== {1'b1, 16'h3000}) begin
                    errors++;
                    $display("FAIL rst_mid_restart: req %b addr %h want 1 3000", imem_req_o_r, imem_addr_o_r);
                end
                en_i_w = 1'b0;
            end
        end
        checks++;
        if (exp_req_q.size() + exp_slot_q.size() != 0) begin
            errors++;
            $display("FAIL rst_mid_drain: %0d req %0d slot left want 0", exp_req_q.size(), exp_slot_q.size());
        end
    endtask

    task automatic test_wrap();
        do_reset();
        en_w = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 0) begin
                checks++;
                if ({req_w, addr_w} !== {1'b1, 16'hFFFF}) begin
                    errors++;
                    $display("FAIL wrap_first: req %b addr %h want 1 ffff", req_w, addr_w);
                end
            end
            if (i == 2) begin
                checks++;
                if ({valid_w, pc_w, npc_w, ir_w, req_w, addr_w} !==
                    {1'b1, 16'hFFFF, 16'h0000, 16'h5A5A, 1'b1, 16'h0000}) begin
                    errors++;
                    $display("FAIL wrap_slot: valid %b pc %h npc %h ir %h req %b addr %h want 1 ffff 0000 5a5a 1 0000",
                             valid_w, pc_w, npc_w, ir_w, req_w, addr_w);
                end
                en_w = 1'b0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_throughput();
        test_stall();
        test_redirect_wait();
        test_redirect_gnt();
        test_redirect_rvalid();
        test_gnt_low();
        test_reset_mid();
        test_wrap();
        mon_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
